// File: rtl/muldiv_pkg.sv
// Shared types for the RV32M multiply/divide sequencer.
// Holds the funct3 opcode enum, the FSM state enum and the default operand width.
package muldiv_pkg;

   localparam int XLEN_DEFAULT = 32;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } muldiv_op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_FIX,
      ST_DONE
   } muldiv_state_e;

   // rs1 is treated as signed for MULH, MULHSU, DIV and REM
   function automatic logic op_rs1_signed(input muldiv_op_e op);
      return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
   endfunction

   // rs2 is treated as signed for MULH, DIV and REM
   function automatic logic op_rs2_signed(input muldiv_op_e op);
      return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Iterative datapath for muldiv_sequencer: operand magnitude capture, a 2*XLEN
// hi/lo shift register, one shared adder/subtractor and the final sign fix-up.
// MULDIV_DIV_EN adds the restoring-divide step; without it only shift-add exists.
// Data registers carry no reset; the sequencer never exposes them before a load.
module muldiv_datapath
   import muldiv_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic             clk,
   input  logic             load,
   input  logic             step,
   input  muldiv_op_e       op,
   input  logic [XLEN-1:0]  rs1,
   input  logic [XLEN-1:0]  rs2,
   output logic [XLEN-1:0]  result
);

   logic              a_neg;
   logic              b_neg;
   logic [XLEN-1:0]   a_mag;
   logic [XLEN-1:0]   b_mag;

   muldiv_op_e        op_q;
   logic              neg_res_q;
   logic [XLEN-1:0]   hi_q;
   logic [XLEN-1:0]   lo_q;
   logic [XLEN-1:0]   mcand_q;
   logic [XLEN-1:0]   hi_d;
   logic [XLEN-1:0]   lo_d;

   logic [XLEN:0]     add_out;
   logic [2*XLEN-1:0] mul_shift;
   logic [2*XLEN-1:0] prod;
   logic [2*XLEN-1:0] prod_fix;

   assign a_neg = op_rs1_signed(op) & rs1[XLEN-1];
   assign b_neg = op_rs2_signed(op) & rs2[XLEN-1];
   assign a_mag = a_neg ? -rs1 : rs1;
   assign b_mag = b_neg ? -rs2 : rs2;

`ifdef MULDIV_DIV_EN
   logic              neg_rem_q;
   logic              div_mode;
   logic              no_borrow;
   logic [XLEN:0]     opa;
   logic [XLEN:0]     opb;
   logic [XLEN+1:0]   sum;

   // Shared adder: hi + mcand when multiplying, {hi,msb(lo)} - divisor when dividing
   assign div_mode  = op_q[2];
   assign opa       = div_mode ? {hi_q, lo_q[XLEN-1]} : {1'b0, hi_q};
   assign opb       = div_mode ? ~{1'b0, mcand_q} : {1'b0, mcand_q};
   assign sum       = {1'b0, opa} + {1'b0, opb} + {{(XLEN+1){1'b0}}, div_mode};
   assign add_out   = sum[XLEN:0];
   assign no_borrow = sum[XLEN+1];
`else
   assign add_out   = {1'b0, hi_q} + {1'b0, mcand_q};
`endif

   // Shift-add: add multiplicand when the multiplier LSB is set, then shift right
   assign mul_shift = {(lo_q[0] ? add_out : {1'b0, hi_q}), lo_q[XLEN-1:1]};

   // Next hi/lo value for one iteration step
   always_comb begin
      hi_d = mul_shift[2*XLEN-1:XLEN];
      lo_d = mul_shift[XLEN-1:0];
`ifdef MULDIV_DIV_EN
      if (div_mode) begin
         hi_d = no_borrow ? add_out[XLEN-1:0] : opa[XLEN-1:0];
         lo_d = {lo_q[XLEN-2:0], no_borrow};
      end
`endif
   end

   // Operand capture on accept, one iteration per cycle while stepping
   always_ff @(posedge clk) begin
      if (load) begin
         op_q      <= op;
         neg_res_q <= a_neg ^ b_neg;
         hi_q      <= '0;
`ifdef MULDIV_DIV_EN
         neg_rem_q <= a_neg;
         if (op[2]) begin
            lo_q    <= a_mag;
            mcand_q <= b_mag;
         end else begin
            lo_q    <= b_mag;
            mcand_q <= a_mag;
         end
`else
         lo_q    <= b_mag;
         mcand_q <= a_mag;
`endif
      end else if (step) begin
         hi_q <= hi_d;
         lo_q <= lo_d;
      end
   end

   assign prod     = {hi_q, lo_q};
   assign prod_fix = neg_res_q ? -prod : prod;

   // Sign fix-up and half/quotient/remainder selection
   always_comb begin
      result = (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
`ifdef MULDIV_DIV_EN
      if (div_mode) begin
         result = op_q[1] ? (neg_rem_q ? -hi_q : hi_q) : (neg_res_q ? -lo_q : lo_q);
      end
`endif
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multi-cycle sequencer: accepts one op, iterates XLEN steps in
// muldiv_datapath, fixes the sign and holds the result until writeback takes it.
// Corner cases (zero divisor, signed overflow, zero MUL operand) bypass the loop.
// MULDIV_DIV_EN enables the divider; otherwise funct3 1xx returns 0 immediately.
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int XLEN      = XLEN_DEFAULT,
   parameter bit SKIP_ZERO = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       req_funct3,
   input  logic [XLEN-1:0]  req_rs1,
   input  logic [XLEN-1:0]  req_rs2,
   input  logic [4:0]       req_rd,
   input  logic             flush,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [XLEN-1:0]  resp_result,
   output logic [4:0]       resp_rd,
   output logic             busy
);

   localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

   muldiv_state_e     state_q;
   muldiv_state_e     state_d;
   logic [CW-1:0]     count_q;
   muldiv_op_e        req_op;
   logic              accept;
   logic              resp_hs;
   logic              fast;
   logic [XLEN-1:0]   fast_result;
   logic              dp_load;
   logic              dp_step;
   logic [XLEN-1:0]   dp_result;

   assign req_op  = muldiv_op_e'(req_funct3);
   assign accept  = req_valid & req_ready & ~flush;
   assign resp_hs = resp_valid & resp_ready;

`ifdef MULDIV_DIV_EN
   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   // Detect requests answered without iterating, and their result
   always_comb begin
      fast        = 1'b0;
      fast_result = '0;
      if (req_funct3[2]) begin
         if (req_rs2 == '0) begin
            fast        = 1'b1;
            fast_result = req_funct3[1] ? req_rs1 : '1;
         end else if (!req_funct3[0] && (req_rs1 == INT_MIN) && (req_rs2 == '1)) begin
            fast        = 1'b1;
            fast_result = req_funct3[1] ? '0 : INT_MIN;
         end
      end else if (SKIP_ZERO && ((req_rs1 == '0) || (req_rs2 == '0))) begin
         fast = 1'b1;
      end
   end
`else
   // Detect requests answered without iterating; every such answer is zero
   always_comb begin
      fast        = 1'b0;
      fast_result = '0;
      if (req_funct3[2]) begin
         fast = 1'b1;
      end else if (SKIP_ZERO && ((req_rs1 == '0) || (req_rs2 == '0))) begin
         fast = 1'b1;
      end
   end
`endif

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic; flush overrides everything
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept) state_d = fast ? ST_DONE : ST_RUN;
         ST_RUN:  if (count_q == '0) state_d = ST_FIX;
         ST_FIX:  state_d = ST_DONE;
         ST_DONE: if (resp_hs) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (flush) state_d = ST_IDLE;
   end

   // FSM outputs
   always_comb begin
      req_ready = (state_q == ST_IDLE);
      busy      = (state_q != ST_IDLE);
      dp_load   = accept & ~fast;
      dp_step   = (state_q == ST_RUN);
   end

   // Iteration counter: XLEN-1 down to 0 gives exactly XLEN steps
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else if (accept) begin
         count_q <= CW'(XLEN - 1);
      end else if (state_q == ST_RUN) begin
         count_q <= count_q - CW'(1);
      end
   end

   // Response registers; resp_valid rises one cycle after entering DONE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         resp_valid  <= 1'b0;
         resp_result <= '0;
         resp_rd     <= '0;
      end else begin
         resp_valid <= (state_q == ST_DONE) & ~flush & ~resp_hs;
         if (accept) begin
            resp_rd <= req_rd;
            if (fast) resp_result <= fast_result;
         end
         if ((state_q == ST_FIX) && !flush) begin
            resp_result <= dp_result;
         end
      end
   end

   muldiv_datapath #(
      .XLEN (XLEN)
   ) u_datapath (
      .clk    (clk),
      .load   (dp_load),
      .step   (dp_step),
      .op     (req_op),
      .rs1    (req_rs1),
      .rs2    (req_rs2),
      .result (dp_result)
   );

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer (XLEN=32, SKIP_ZERO=1).
// Divider vectors apply when MULDIV_DIV_EN is defined; otherwise the
// divide-disabled fast path is exercised.
module tb_muldiv_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_funct3;
   logic [31:0] req_rs1;
   logic [31:0] req_rs2;
   logic [4:0]  req_rd;
   logic        flush;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_result;
   logic [4:0]  resp_rd;
   logic        busy;

   int n_chk = 0;
   int n_err = 0;

   muldiv_sequencer #(
      .XLEN      (32),
      .SKIP_ZERO (1'b1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_funct3  (req_funct3),
      .req_rs1     (req_rs1),
      .req_rs2     (req_rs2),
      .req_rd      (req_rd),
      .flush       (flush),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_result (resp_result),
      .resp_rd     (resp_rd),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one request and return just after the accepting edge
   task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
      int w = 0;
      while (!req_ready && w < 100) begin
         tick();
         w++;
      end
      chk("req_ready_before_issue", {31'd0, req_ready}, 32'd1);
      req_valid  = 1'b1;
      req_funct3 = f3;
      req_rs1    = a;
      req_rs2    = b;
      req_rd     = rd;
      tick();
      req_valid  = 1'b0;
   endtask

   // Count edges after accept until resp_valid is seen (bounded)
   task automatic wait_resp(output int lat);
      lat = 0;
      while (!resp_valid && lat < 100) begin
         tick();
         lat++;
      end
   endtask

   task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_res, input int exp_lat);
      int lat;
      issue(f3, a, b, rd);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      wait_resp(lat);
      chk({tag, "_lat"}, lat, exp_lat);
      chk({tag, "_res"}, resp_result, exp_res);
      chk({tag, "_rd"}, {27'd0, resp_rd}, {27'd0, rd});
      tick();
   endtask

   initial begin
      int lat;
      logic ok;

      rst        = 1'b1;
      req_valid  = 1'b0;
      req_funct3 = 3'b000;
      req_rs1    = '0;
      req_rs2    = '0;
      req_rd     = '0;
      flush      = 1'b0;
      resp_ready = 1'b1;
      repeat (3) tick();
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_resp_result", resp_result, 32'd0);
      chk("rst_resp_rd", {27'd0, resp_rd}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      tick();

      // Multiplies through the iterative path
      do_op("mul7x6",     3'b000, 32'd7,        32'd6,        5'd5,  32'd42,       34);
      do_op("mulh_min",   3'b001, 32'h80000000, 32'h80000000, 5'd1,  32'h40000000, 34);
      do_op("mulhu_max",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, 34);
      do_op("mulhsu_m1",  3'b010, 32'hFFFFFFFF, 32'd2,        5'd3,  32'hFFFFFFFF, 34);
      do_op("mul_neg",    3'b000, 32'hFFFFFFFD, 32'd5,        5'd4,  32'hFFFFFFF1, 34);
      do_op("mulh_neg",   3'b001, 32'hFFFFFFFD, 32'd5,        5'd6,  32'hFFFFFFFF, 34);

      // Zero operand skips the loop
      do_op("mul_zero_a", 3'b000, 32'd0,        32'd123,      5'd7,  32'd0,        1);
      do_op("mulhu_zero", 3'b011, 32'd5,        32'd0,        5'd8,  32'd0,        1);

`ifdef MULDIV_DIV_EN
      do_op("div_m7_2",   3'b100, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFD, 34);
      do_op("rem_m7_2",   3'b110, 32'hFFFFFFF9, 32'd2,        5'd11, 32'hFFFFFFFF, 34);
      do_op("remu_17_5",  3'b111, 32'd17,       32'd5,        5'd12, 32'd2,        34);
      do_op("divu_by0",   3'b101, 32'd5,        32'd0,        5'd13, 32'hFFFFFFFF, 1);
      do_op("remu_by0",   3'b111, 32'd5,        32'd0,        5'd14, 32'd5,        1);
      do_op("div_ovf",    3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 1);
      do_op("rem_ovf",    3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'd0,        1);
`else
      do_op("div_off",    3'b100, 32'd10,       32'd2,        5'd10, 32'd0,        1);
      do_op("divu_by0",   3'b101, 32'd5,        32'd0,        5'd13, 32'd0,        1);
`endif

      // Back-pressure: result and rd held while writeback stalls
      resp_ready = 1'b0;
      issue(3'b000, 32'd3, 32'd4, 5'd9);
      wait_resp(lat);
      chk("bp_lat", lat, 34);
      ok = 1'b1;
      repeat (10) begin
         tick();
         if (!(resp_valid && resp_result == 32'd12 && resp_rd == 5'd9 && !req_ready)) ok = 1'b0;
      end
      chk("bp_hold", {31'd0, ok}, 32'd1);
      resp_ready = 1'b1;
      chk("bp_ready_before_hs", {31'd0, req_ready}, 32'd0);
      tick();
      chk("bp_valid_after_hs", {31'd0, resp_valid}, 32'd0);
      chk("bp_ready_after_hs", {31'd0, req_ready}, 32'd1);

      // Flush in RUN, then a new op right away with full latency
      issue(3'b000, 32'd100, 32'd100, 5'd20);
      repeat (5) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_run_busy", {31'd0, busy}, 32'd0);
      do_op("mul3x3",     3'b000, 32'd3,        32'd3,        5'd21, 32'd9,        34);

      // Flush while DONE is unacknowledged
      resp_ready = 1'b0;
      issue(3'b000, 32'd2, 32'd2, 5'd22);
      wait_resp(lat);
      chk("flush_done_lat", lat, 34);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_done_valid", {31'd0, resp_valid}, 32'd0);
      chk("flush_done_busy", {31'd0, busy}, 32'd0);
      resp_ready = 1'b1;

      // Flush together with a request in IDLE drops the request
      req_valid  = 1'b1;
      req_funct3 = 3'b000;
      req_rs1    = 32'd0;
      req_rs2    = 32'd2;
      req_rd     = 5'd23;
      flush      = 1'b1;
      tick();
      req_valid  = 1'b0;
      flush      = 1'b0;
      chk("flush_idle_busy", {31'd0, busy}, 32'd0);
      ok = 1'b1;
      repeat (3) begin
         tick();
         if (resp_valid) ok = 1'b0;
      end
      chk("flush_idle_noresp", {31'd0, ok}, 32'd1);

      // Asynchronous reset in the middle of RUN
      issue(3'b000, 32'd7, 32'd6, 5'd24);
      repeat (10) tick();
      rst = 1'b1;
      #1;
      chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("midrst_resp_result", resp_result, 32'd0);
      chk("midrst_resp_rd", {27'd0, resp_rd}, 32'd0);
      tick();
      rst = 1'b0;
      tick();
      do_op("mul5x5",     3'b000, 32'd5,        32'd5,        5'd25, 32'd25,       34);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
